// File: rtl/vgafb_graycounter_ud.sv
// Up/down Gray-code counter with clear, load, wrap/saturate, look-ahead Gray and terminal flag.
// Down counting is compiled in only when VGAFB_GRAYCNT_DOWN_EN is defined.
module vgafb_graycounter_ud #(
   parameter int unsigned COUNTER_WIDTH = 4,
   parameter int unsigned RESET_VALUE   = 0,
   parameter int unsigned SATURATE      = 0
) (
   input  logic                     Clk,
   input  logic                     Reset_n_in,
   input  logic                     Clear_in,
   input  logic                     Load_in,
   input  logic [COUNTER_WIDTH-1:0] LoadValue_in,
   input  logic                     Enable_in,
   input  logic                     Down_in,
   output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
   output logic [COUNTER_WIDTH-1:0] GrayCount_out,
   output logic [COUNTER_WIDTH-1:0] GrayNext_out,
   output logic                     Term_out
);

   typedef logic [COUNTER_WIDTH-1:0] count_t;

   function automatic count_t to_gray(input count_t b);
      return b ^ (b >> 1);
   endfunction

   localparam count_t RESET_BIN  = COUNTER_WIDTH'(RESET_VALUE);
   localparam count_t RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
   localparam count_t ONE        = COUNTER_WIDTH'(1);

   count_t bin_q;
   count_t gray_q;
   logic   term_q;
   count_t step_bin;
   logic   at_term;

`ifdef VGAFB_GRAYCNT_DOWN_EN
   logic down;
   assign down = Down_in;

   always_comb begin
      step_bin = bin_q;
      at_term  = down ? (bin_q == '0) : (bin_q == '1);
      if (at_term) begin
         if (SATURATE == 0)
            step_bin = down ? '1 : '0;
      end else if (down) begin
         step_bin = bin_q - ONE;
      end else begin
         step_bin = bin_q + ONE;
      end
   end
`else
   logic unused_down;
   assign unused_down = Down_in;

   always_comb begin
      step_bin = bin_q;
      at_term  = (bin_q == '1);
      if (at_term) begin
         if (SATURATE == 0)
            step_bin = '0;
      end else begin
         step_bin = bin_q + ONE;
      end
   end
`endif

   // Binary and Gray registers update together so the Gray output never lags.
   always_ff @(posedge Clk or negedge Reset_n_in) begin
      if (!Reset_n_in) begin
         bin_q  <= RESET_BIN;
         gray_q <= RESET_GRAY;
         term_q <= 1'b0;
      end else if (Clear_in) begin
         bin_q  <= RESET_BIN;
         gray_q <= RESET_GRAY;
         term_q <= 1'b0;
      end else if (Load_in) begin
         bin_q  <= LoadValue_in;
         gray_q <= to_gray(LoadValue_in);
         term_q <= 1'b0;
      end else if (Enable_in) begin
         bin_q  <= step_bin;
         gray_q <= to_gray(step_bin);
         term_q <= at_term;
      end else begin
         term_q <= 1'b0;
      end
   end

   assign BinaryCount_out = bin_q;
   assign GrayCount_out   = gray_q;
   assign GrayNext_out    = to_gray(step_bin);
   assign Term_out        = term_q;

endmodule
